// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic ranger scheduler: fires one trig/echo pair at a time,
// times the echo pulse in centimetres and keeps a per-sensor distance bank and near flags.
module sonar_scheduler #(
   parameter int unsigned N_SENSORS    = 4,
   parameter int unsigned DIST_W       = 8,
   parameter int unsigned TRIG_CYCLES  = 500,
   parameter int unsigned CM_CYCLES    = 2900,
   parameter int unsigned RISE_TIMEOUT = 1_500_000,
   parameter int unsigned ECHO_TIMEOUT = 1_900_000,
   parameter int unsigned GAP_CYCLES   = 3_000_000,
   parameter int unsigned NEAR_CM      = 20
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 enable,
   input  logic [N_SENSORS-1:0]                                 sensor_mask,
   input  logic [N_SENSORS-1:0]                                 echo,
   output logic [N_SENSORS-1:0]                                 trig,
   output logic [N_SENSORS*DIST_W-1:0]                          dist_bank,
   output logic [N_SENSORS-1:0]                                 near,
   output logic                                                 result_valid,
   output logic [$clog2(N_SENSORS > 1 ? N_SENSORS : 2)-1:0]     result_idx,
   output logic [DIST_W-1:0]                                    result_dist,
   output logic                                                 result_tmo,
   output logic                                                 busy
);

   localparam int unsigned IDX_W = $clog2(N_SENSORS > 1 ? N_SENSORS : 2);
   localparam int unsigned CW    = IDX_W + 1;
   localparam int unsigned T_A   = (TRIG_CYCLES > RISE_TIMEOUT) ? TRIG_CYCLES : RISE_TIMEOUT;
   localparam int unsigned T_B   = (ECHO_TIMEOUT > GAP_CYCLES) ? ECHO_TIMEOUT : GAP_CYCLES;
   localparam int unsigned T_MAX = (T_A > T_B) ? T_A : T_B;
   localparam int unsigned TMR_W = $clog2(T_MAX + 1);
   localparam int unsigned PRE_W = $clog2(CM_CYCLES + 1);
   localparam logic [DIST_W-1:0] DIST_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_GAP
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [TMR_W-1:0]     tmr;
   logic [PRE_W-1:0]     pre;
   logic [DIST_W-1:0]    cm;
   logic [IDX_W-1:0]     sel;
   logic [IDX_W-1:0]     rr;
   logic [N_SENSORS-1:0] echo_s1;
   logic [N_SENSORS-1:0] echo_s2;
   logic [N_SENSORS-1:0] echo_prev;

   logic                 rise_c;
   logic                 fall_c;
   logic                 pick_found_c;
   logic [IDX_W-1:0]     pick_idx_c;
   logic [CW-1:0]        cand_c;
   logic [IDX_W-1:0]     rr_nxt_c;
   logic [DIST_W-1:0]    cm_step_c;
   logic                 wr_c;
   logic [DIST_W-1:0]    wr_dist_c;
   logic                 wr_tmo_c;
   logic [N_SENSORS-1:0] trig_nxt_c;
   logic                 wr_near_c;

   // Two-flop synchroniser plus one history stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         echo_s1   <= '0;
         echo_s2   <= '0;
         echo_prev <= '0;
      end else begin
         echo_s1   <= echo;
         echo_s2   <= echo_s1;
         echo_prev <= echo_s2;
      end
   end

   assign rise_c = echo_s2[sel] & ~echo_prev[sel];
   assign fall_c = ~echo_s2[sel] & echo_prev[sel];

   // First enabled sensor at or after the round-robin pointer; lowest offset wins
   always_comb begin
      pick_found_c = 1'b0;
      pick_idx_c   = '0;
      cand_c       = '0;
      for (int i = int'(N_SENSORS) - 1; i >= 0; i--) begin
         cand_c = CW'(rr) + CW'(i);
         if (cand_c >= CW'(N_SENSORS)) begin
            cand_c = cand_c - CW'(N_SENSORS);
         end
         if (sensor_mask[cand_c[IDX_W-1:0]]) begin
            pick_found_c = 1'b1;
            pick_idx_c   = cand_c[IDX_W-1:0];
         end
      end
   end

   assign rr_nxt_c  = (sel == IDX_W'(N_SENSORS - 1)) ? '0 : sel + IDX_W'(1);
   assign cm_step_c = (pre == PRE_W'(CM_CYCLES - 1) && cm != DIST_MAX) ? cm + DIST_W'(1) : cm;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (enable && pick_found_c) state_nxt = S_TRIG;
         end
         S_TRIG: begin
            if (tmr == TMR_W'(TRIG_CYCLES - 1)) state_nxt = S_WAIT_RISE;
         end
         S_WAIT_RISE: begin
            if (rise_c) state_nxt = S_MEASURE;
            else if (tmr == TMR_W'(RISE_TIMEOUT - 1)) state_nxt = S_GAP;
         end
         S_MEASURE: begin
            if (fall_c || tmr == TMR_W'(ECHO_TIMEOUT - 1)) state_nxt = S_GAP;
         end
         S_GAP: begin
            if (tmr == TMR_W'(GAP_CYCLES - 1)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: result write strobe/payload and next trigger vector.
   // An echo that outlives its timeout reports the distance accrued up to the limit.
   always_comb begin
      wr_c       = 1'b0;
      wr_dist_c  = DIST_MAX;
      wr_tmo_c   = 1'b0;
      trig_nxt_c = '0;
      case (state)
         S_WAIT_RISE: begin
            if (!rise_c && tmr == TMR_W'(RISE_TIMEOUT - 1)) begin
               wr_c     = 1'b1;
               wr_tmo_c = 1'b1;
            end
         end
         S_MEASURE: begin
            if (fall_c) begin
               wr_c      = 1'b1;
               wr_dist_c = cm_step_c;
            end else if (tmr == TMR_W'(ECHO_TIMEOUT - 1)) begin
               wr_c      = 1'b1;
               wr_dist_c = cm_step_c;
               wr_tmo_c  = 1'b1;
            end
         end
         default: ;
      endcase
      if (state_nxt == S_TRIG) begin
         trig_nxt_c = N_SENSORS'(1) << ((state == S_IDLE) ? pick_idx_c : sel);
      end
   end

   assign wr_near_c = !wr_tmo_c && (32'(wr_dist_c) < NEAR_CM);

   // Slot timer, selection, round-robin pointer and echo-width counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr <= '0;
         pre <= '0;
         cm  <= '0;
         sel <= '0;
         rr  <= '0;
      end else begin
         if (state_nxt != state || state == S_IDLE) tmr <= '0;
         else tmr <= tmr + TMR_W'(1);

         if (state == S_IDLE && state_nxt == S_TRIG) sel <= pick_idx_c;

         if (state == S_MEASURE) begin
            pre <= (pre == PRE_W'(CM_CYCLES - 1)) ? '0 : pre + PRE_W'(1);
            cm  <= cm_step_c;
         end else begin
            pre <= '0;
            cm  <= '0;
         end

         if (state == S_GAP && state_nxt == S_IDLE) rr <= rr_nxt_c;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig         <= '0;
         busy         <= 1'b0;
         dist_bank    <= '1;
         near         <= '0;
         result_valid <= 1'b0;
         result_idx   <= '0;
         result_dist  <= '0;
         result_tmo   <= 1'b0;
      end else begin
         trig         <= trig_nxt_c;
         busy         <= (state_nxt != S_IDLE);
         result_valid <= wr_c;
         if (wr_c) begin
            result_idx  <= sel;
            result_dist <= wr_dist_c;
            result_tmo  <= wr_tmo_c;
         end
         for (int i = 0; i < int'(N_SENSORS); i++) begin
            if (wr_c && sel == IDX_W'(i)) begin
               dist_bank[i*DIST_W +: DIST_W] <= wr_dist_c;
               near[i]                       <= wr_near_c;
            end
         end
      end
   end

endmodule
